// File: rtl/reg_hilo_mp_pkg.sv
// Shared constants for the HI/LO special register slice.
package reg_hilo_mp_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] Zero32      = 32'h0000_0000;
    localparam int          HILO_DATA_W = 32;
    localparam int          MDU_TAG_W   = 3;

endpackage

// File: rtl/hilo_lane_merge.sv
// Picks the youngest (highest-index) enabled write lane for one HI/LO field.
module hilo_lane_merge #(
    parameter int DATA_W = 32,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        en,
    input  logic [NUM_WR*DATA_W-1:0] data,
    output logic                     any_en,
    output logic [DATA_W-1:0]        win_data
);

    // Ascending scan: a later (younger) lane overwrites an earlier one.
    always_comb begin
        any_en   = 1'b0;
        win_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (en[i]) begin
                any_en   = 1'b1;
                win_data = data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_hilo_mp.sv
// HI/LO special register: multi-lane writes, same-cycle forwarding, one tagged
// outstanding MDU op whose result is suppressed per field by younger MTHI/MTLO.
module reg_hilo_mp
    import reg_hilo_mp_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W,
    parameter int NUM_WR = 2,
    parameter int TAG_W  = MDU_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_hi_en,
    input  logic [NUM_WR-1:0]        wr_lo_en,
    input  logic [NUM_WR*DATA_W-1:0] wr_hi_data,
    input  logic [NUM_WR*DATA_W-1:0] wr_lo_data,
    input  logic                     flush,
    input  logic                     mdu_issue_valid,
    input  logic [TAG_W-1:0]         mdu_issue_tag,
    output logic                     mdu_issue_ready,
    input  logic                     mdu_done_valid,
    input  logic [TAG_W-1:0]         mdu_done_tag,
    input  logic [DATA_W-1:0]        mdu_done_hi,
    input  logic [DATA_W-1:0]        mdu_done_lo,
    output logic [DATA_W-1:0]        hi_o,
    output logic [DATA_W-1:0]        lo_o,
    output logic [DATA_W-1:0]        hi_fwd_o,
    output logic [DATA_W-1:0]        lo_fwd_o,
    output logic                     busy_o
);

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] hi_next, lo_next;
    logic [DATA_W-1:0] hi_lane, lo_lane;
    logic              hi_any, lo_any;
    logic              busy_q, busy_next;
    logic [TAG_W-1:0]  pend_tag, pend_tag_next;
    logic              kill_hi, kill_lo, kill_hi_next, kill_lo_next;
    logic              in_rst, issue_acc, done_match, hi_wr, lo_wr;

    hilo_lane_merge #(.DATA_W(DATA_W), .NUM_WR(NUM_WR)) u_merge_hi (
        .en       (wr_hi_en),
        .data     (wr_hi_data),
        .any_en   (hi_any),
        .win_data (hi_lane)
    );

    hilo_lane_merge #(.DATA_W(DATA_W), .NUM_WR(NUM_WR)) u_merge_lo (
        .en       (wr_lo_en),
        .data     (wr_lo_data),
        .any_en   (lo_any),
        .win_data (lo_lane)
    );

    // Issue handshake: an op transfers when mdu_issue_valid && mdu_issue_ready
    // (and no flush); valid without ready is dropped, never queued.
    assign in_rst     = (rst == RstEnable);
    assign issue_acc  = mdu_issue_valid && !busy_q && !flush;
    assign done_match = mdu_done_valid && busy_q && (mdu_done_tag == pend_tag) && !flush;
    assign hi_wr      = hi_any && !flush;
    assign lo_wr      = lo_any && !flush;

    always_comb begin
        hi_next       = hi_q;
        lo_next       = lo_q;
        busy_next     = busy_q;
        pend_tag_next = pend_tag;
        kill_hi_next  = kill_hi;
        kill_lo_next  = kill_lo;
        if (in_rst) begin
            hi_next       = '0;
            lo_next       = '0;
            busy_next     = 1'b0;
            pend_tag_next = '0;
            kill_hi_next  = 1'b0;
            kill_lo_next  = 1'b0;
        end else if (flush) begin
            busy_next    = 1'b0;
            kill_hi_next = 1'b0;
            kill_lo_next = 1'b0;
        end else begin
            if (hi_wr) begin
                hi_next = hi_lane;
            end else if (done_match && !kill_hi) begin
                hi_next = mdu_done_hi;
            end
            if (lo_wr) begin
                lo_next = lo_lane;
            end else if (done_match && !kill_lo) begin
                lo_next = mdu_done_lo;
            end
            if (issue_acc) begin
                busy_next     = 1'b1;
                pend_tag_next = mdu_issue_tag;
                kill_hi_next  = 1'b0;
                kill_lo_next  = 1'b0;
            end else if (done_match) begin
                busy_next    = 1'b0;
                kill_hi_next = 1'b0;
                kill_lo_next = 1'b0;
            end else if (busy_q) begin
                // A younger MTHI/MTLO must survive the pending MDU result.
                kill_hi_next = kill_hi || hi_wr;
                kill_lo_next = kill_lo || lo_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        hi_q     <= hi_next;
        lo_q     <= lo_next;
        busy_q   <= busy_next;
        pend_tag <= pend_tag_next;
        kill_hi  <= kill_hi_next;
        kill_lo  <= kill_lo_next;
    end

    assign hi_o            = hi_q;
    assign lo_o            = lo_q;
    assign hi_fwd_o        = hi_next;
    assign lo_fwd_o        = lo_next;
    assign busy_o          = busy_q;
    assign mdu_issue_ready = !busy_q;

endmodule

// File: tb/tb_reg_hilo_mp.sv
// Directed plus randomized bench for reg_hilo_mp against an event-ordered model.
module tb_reg_hilo_mp;

    localparam int DW = 32;
    localparam int NW = 2;
    localparam int TW = 3;

    logic            clk;
    logic            rst;
    logic [NW-1:0]   wr_hi_en, wr_lo_en;
    logic [NW*DW-1:0] wr_hi_data, wr_lo_data;
    logic            flush;
    logic            mdu_issue_valid;
    logic [TW-1:0]   mdu_issue_tag;
    logic            mdu_issue_ready;
    logic            mdu_done_valid;
    logic [TW-1:0]   mdu_done_tag;
    logic [DW-1:0]   mdu_done_hi, mdu_done_lo;
    logic [DW-1:0]   hi_o, lo_o, hi_fwd_o, lo_fwd_o;
    logic            busy_o;

    int tests = 0;
    int fails = 0;

    reg_hilo_mp #(.DATA_W(DW), .NUM_WR(NW), .TAG_W(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_hi_en        (wr_hi_en),
        .wr_lo_en        (wr_lo_en),
        .wr_hi_data      (wr_hi_data),
        .wr_lo_data      (wr_lo_data),
        .flush           (flush),
        .mdu_issue_valid (mdu_issue_valid),
        .mdu_issue_tag   (mdu_issue_tag),
        .mdu_issue_ready (mdu_issue_ready),
        .mdu_done_valid  (mdu_done_valid),
        .mdu_done_tag    (mdu_done_tag),
        .mdu_done_hi     (mdu_done_hi),
        .mdu_done_lo     (mdu_done_lo),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .hi_fwd_o        (hi_fwd_o),
        .lo_fwd_o        (lo_fwd_o),
        .busy_o          (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          busy;
        logic [TW-1:0] tag;
        logic          kill_hi;
        logic          kill_lo;
    } model_t;

    model_t m;

    // Events applied in program order: MDU result first, then lanes oldest to
    // youngest, so a later writer simply overwrites an earlier one.
    function automatic model_t model_next(model_t s);
        model_t n;
        n = s;
        if (rst) begin
            n = '0;
            return n;
        end
        if (flush) begin
            n.busy    = 1'b0;
            n.kill_hi = 1'b0;
            n.kill_lo = 1'b0;
            return n;
        end
        if (mdu_done_valid && s.busy && mdu_done_tag == s.tag) begin
            if (!s.kill_hi) n.hi = mdu_done_hi;
            if (!s.kill_lo) n.lo = mdu_done_lo;
            n.busy = 1'b0;
        end
        for (int i = 0; i < NW; i++) begin
            if (wr_hi_en[i]) begin
                n.hi = wr_hi_data[i*DW +: DW];
                if (s.busy) n.kill_hi = 1'b1;
            end
            if (wr_lo_en[i]) begin
                n.lo = wr_lo_data[i*DW +: DW];
                if (s.busy) n.kill_lo = 1'b1;
            end
        end
        if (mdu_issue_valid && !s.busy) begin
            n.busy    = 1'b1;
            n.tag     = mdu_issue_tag;
            n.kill_hi = 1'b0;
            n.kill_lo = 1'b0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst             = 1'b0;
        wr_hi_en        = '0;
        wr_lo_en        = '0;
        wr_hi_data      = '0;
        wr_lo_data      = '0;
        flush           = 1'b0;
        mdu_issue_valid = 1'b0;
        mdu_issue_tag   = '0;
        mdu_done_valid  = 1'b0;
        mdu_done_tag    = '0;
        mdu_done_hi     = '0;
        mdu_done_lo     = '0;
    endtask

    // Checks forwarding before the edge and registered state after it.
    task automatic cycle(input string tag);
        model_t n;
        #1;
        n = model_next(m);
        check({tag, ".hi_fwd"}, hi_fwd_o, n.hi);
        check({tag, ".lo_fwd"}, lo_fwd_o, n.lo);
        if (!rst) check({tag, ".ready"}, {31'b0, mdu_issue_ready}, {31'b0, !m.busy});
        @(posedge clk);
        #1;
        m = n;
        check({tag, ".hi"}, hi_o, m.hi);
        check({tag, ".lo"}, lo_o, m.lo);
        check({tag, ".busy"}, {31'b0, busy_o}, {31'b0, m.busy});
    endtask

    logic [DW-1:0] save_hi, save_lo;

    initial begin
        m = '0;
        idle();
        rst = 1'b1;
        cycle("rst0");
        cycle("rst1");
        idle();
        #1;
        check("t1.hi", hi_o, 32'h0);
        check("t1.lo", lo_o, 32'h0);
        check("t1.busy", {31'b0, busy_o}, 32'h0);
        check("t1.ready", {31'b0, mdu_issue_ready}, 32'h1);

        // Two lanes write HI together: the younger lane wins.
        wr_hi_en   = 2'b11;
        wr_hi_data = {32'h2222_2222, 32'h1111_1111};
        #1;
        check("t2.fwd_direct", hi_fwd_o, 32'h2222_2222);
        cycle("t2");
        check("t2.hi_direct", hi_o, 32'h2222_2222);
        check("t2.lo_direct", lo_o, 32'h0);
        idle();

        // Issue tag 3, wrong-tag done ignored, matching done lands.
        mdu_issue_valid = 1'b1; mdu_issue_tag = 3'd3;
        cycle("t3.issue");
        idle();
        mdu_done_valid = 1'b1; mdu_done_tag = 3'd5; mdu_done_hi = 32'hF0; mdu_done_lo = 32'hF1;
        cycle("t3.badtag");
        check("t3.busy_after_bad", {31'b0, busy_o}, 32'h1);
        mdu_done_tag = 3'd3; mdu_done_hi = 32'hA; mdu_done_lo = 32'hB;
        cycle("t3.done");
        check("t3.hi_direct", hi_o, 32'hA);
        check("t3.lo_direct", lo_o, 32'hB);
        check("t3.busy_direct", {31'b0, busy_o}, 32'h0);
        idle();

        // MTLO while busy kills the LO part of the later result.
        mdu_issue_valid = 1'b1; mdu_issue_tag = 3'd1;
        cycle("t4.issue");
        idle();
        wr_lo_en = 2'b01; wr_lo_data = {32'h0, 32'h55};
        cycle("t4.mtlo");
        idle();
        mdu_done_valid = 1'b1; mdu_done_tag = 3'd1; mdu_done_hi = 32'hC; mdu_done_lo = 32'hD;
        cycle("t4.done");
        check("t4.hi_direct", hi_o, 32'hC);
        check("t4.lo_direct", lo_o, 32'h55);
        idle();

        // Flush drops the outstanding op; its later done changes nothing.
        save_hi = hi_o; save_lo = lo_o;
        mdu_issue_valid = 1'b1; mdu_issue_tag = 3'd2;
        cycle("t5.issue");
        idle();
        flush = 1'b1;
        cycle("t5.flush");
        check("t5.busy_direct", {31'b0, busy_o}, 32'h0);
        idle();
        mdu_done_valid = 1'b1; mdu_done_tag = 3'd2; mdu_done_hi = 32'hEE; mdu_done_lo = 32'hEF;
        cycle("t5.stale_done");
        check("t5.hi_direct", hi_o, save_hi);
        check("t5.lo_direct", lo_o, save_lo);
        idle();

        // Done and lane HI in the same cycle; then reset while busy.
        mdu_issue_valid = 1'b1; mdu_issue_tag = 3'd4;
        cycle("t6.issue");
        idle();
        mdu_done_valid = 1'b1; mdu_done_tag = 3'd4; mdu_done_hi = 32'h99; mdu_done_lo = 32'h88;
        wr_hi_en = 2'b10; wr_hi_data = {32'h77, 32'h0};
        cycle("t6.both");
        check("t6.hi_direct", hi_o, 32'h77);
        check("t6.lo_direct", lo_o, 32'h88);
        idle();
        mdu_issue_valid = 1'b1; mdu_issue_tag = 3'd6;
        cycle("t6.issue2");
        idle();
        rst = 1'b1;
        wr_hi_en = 2'b11; wr_hi_data = {32'h1234, 32'h5678};
        cycle("t6.rst");
        check("t6.rst_hi", hi_o, 32'h0);
        check("t6.rst_lo", lo_o, 32'h0);
        check("t6.rst_busy", {31'b0, busy_o}, 32'h0);
        check("t6.rst_ready", {31'b0, mdu_issue_ready}, 32'h1);
        idle();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst             = ($urandom_range(0, 59) == 0);
            flush           = ($urandom_range(0, 19) == 0);
            wr_hi_en        = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            wr_lo_en        = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            wr_hi_data      = {$urandom, $urandom};
            wr_lo_data      = {$urandom, $urandom};
            mdu_issue_valid = ($urandom_range(0, 2) == 0);
            mdu_issue_tag   = TW'($urandom);
            mdu_done_valid  = ($urandom_range(0, 1) == 0);
            mdu_done_tag    = ($urandom_range(0, 2) != 0) ? m.tag : TW'($urandom);
            mdu_done_hi     = $urandom;
            mdu_done_lo     = $urandom;
            cycle("rand");
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
